// File: rtl/tomasulo_pkg.sv
// Shared definitions for the fetch/issue front end: fetch FSM encoding and default widths.
// Pure declarations, no latency or flow control of its own.
package tomasulo_pkg;
    localparam int INSTR_W_DEF = 16;
    localparam int ADDR_W_DEF  = 4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
endpackage

// File: rtl/ifq_fifo.sv
// Synchronous FIFO of {pc,instr} entries with flush; push-to-head visibility is 1 cycle.
// Backpressure: a push into a full FIFO is taken only if the head pops in the same cycle.
module ifq_fifo #(
    parameter int W     = 20,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic         clk1,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    input  logic         flush,
    output logic [W-1:0] head_dat,
    output logic [CW-1:0] count,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk1) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk1) begin
        if (do_push && !(rst || flush)) mem[wr_ptr] <= push_dat;
    end
endmodule

// File: rtl/instruction_fetch_queue.sv
// Instruction memory + autonomous fetch engine + in-order issue queue; start to first issue_valid is 2 cycles.
// Backpressure: issue_ready low stalls the head; fetch stops launching once queue plus in-flight read fills QDEPTH.
module instruction_fetch_queue
    import tomasulo_pkg::*;
#(
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int QDEPTH  = 4
) (
    input  logic                      clk1,
    input  logic                      rst,
    input  logic                      prog_we,
    input  logic [ADDR_W-1:0]         prog_addr,
    input  logic [INSTR_W-1:0]        prog_data,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         start_pc,
    input  logic [ADDR_W-1:0]         end_pc,
    input  logic                      redirect,
    input  logic [ADDR_W-1:0]         redirect_pc,
    input  logic                      issue_ready,
    output logic                      issue_valid,
    output logic [INSTR_W-1:0]        issue_instr,
    output logic [ADDR_W-1:0]         issue_pc,
    output logic                      busy,
    output logic                      done,
    output logic [$clog2(QDEPTH):0]   q_count
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CW    = $clog2(QDEPTH) + 1;

    logic [INSTR_W-1:0]        mem [DEPTH];
    logic [1:0]                state;
    logic [ADDR_W-1:0]         pc;
    logic [ADDR_W-1:0]         last_pc;
    logic [ADDR_W-1:0]         rd_pc;
    logic [ADDR_W-1:0]         rd_addr;
    logic [INSTR_W-1:0]        rd_dat;
    logic                      inflight;
    logic                      idle_like;
    logic                      redir_go;
    logic                      start_go;
    logic                      launch;
    logic                      pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [ADDR_W+INSTR_W-1:0] head_dat;

    assign idle_like = (state == S_IDLE) || (state == S_DONE);
    assign redir_go  = redirect && !idle_like;
    assign start_go  = start && idle_like;
    assign pop       = issue_valid && issue_ready;
    assign rd_addr   = start_go ? start_pc : pc;

    // The in-flight read already owns a queue slot, so its data always has room on return.
    assign launch = start_go ||
                    ((state == S_FETCH) && !redir_go && !fifo_full &&
                     ((q_count + CW'(inflight)) < CW'(QDEPTH)));

    always_ff @(posedge clk1) begin
        if (prog_we && idle_like) mem[prog_addr] <= prog_data;
        if (launch)               rd_dat <= mem[rd_addr];
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            state    <= S_IDLE;
            pc       <= '0;
            last_pc  <= '0;
            rd_pc    <= '0;
            inflight <= 1'b0;
        end else if (redir_go) begin
            state    <= S_FETCH;
            pc       <= redirect_pc;
            inflight <= 1'b0;
        end else begin
            inflight <= launch;
            if (launch) begin
                rd_pc <= rd_addr;
                pc    <= rd_addr + 1'b1;
            end
            if (start_go) last_pc <= end_pc;
            case (state)
                S_IDLE, S_DONE: if (start_go) state <= (start_pc == end_pc) ? S_DRAIN : S_FETCH;
                S_FETCH:        if (launch && (pc == last_pc)) state <= S_DRAIN;
                S_DRAIN:        if (!inflight && fifo_empty) state <= S_DONE;
                default:        state <= S_IDLE;
            endcase
        end
    end

    ifq_fifo #(
        .W     (ADDR_W + INSTR_W),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk1     (clk1),
        .rst      (rst),
        .push     (inflight),
        .push_dat ({rd_pc, rd_dat}),
        .pop      (pop),
        .flush    (redir_go),
        .head_dat (head_dat),
        .count    (q_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign {issue_pc, issue_instr} = head_dat;
    assign issue_valid = !fifo_empty;
    assign busy        = (state == S_FETCH) || (state == S_DRAIN);
    assign done        = (state == S_DONE);
endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Bench for instruction_fetch_queue: cycle table for the basic run, directed corner sequences,
// and randomized runs scored against an in-order list of PCs expected to issue.
module tb_instruction_fetch_queue;
    localparam int INSTR_W = 16;
    localparam int ADDR_W  = 4;
    localparam int QDEPTH  = 4;
    localparam int CW      = $clog2(QDEPTH) + 1;

    logic                clk1 = 1'b0;
    logic                rst;
    logic                prog_we;
    logic [ADDR_W-1:0]   prog_addr;
    logic [INSTR_W-1:0]  prog_data;
    logic                start;
    logic [ADDR_W-1:0]   start_pc;
    logic [ADDR_W-1:0]   end_pc;
    logic                redirect;
    logic [ADDR_W-1:0]   redirect_pc;
    logic                issue_ready;
    logic                issue_valid;
    logic [INSTR_W-1:0]  issue_instr;
    logic [ADDR_W-1:0]   issue_pc;
    logic                busy;
    logic                done;
    logic [CW-1:0]       q_count;

    always #5 clk1 = ~clk1;

    instruction_fetch_queue #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .QDEPTH(QDEPTH)) dut (
        .clk1(clk1), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .start(start), .start_pc(start_pc), .end_pc(end_pc), .redirect(redirect),
        .redirect_pc(redirect_pc), .issue_ready(issue_ready), .issue_valid(issue_valid),
        .issue_instr(issue_instr), .issue_pc(issue_pc), .busy(busy), .done(done), .q_count(q_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [INSTR_W-1:0] mdl_mem [16];
    logic [ADDR_W-1:0]  exp_q [$];
    logic [ADDR_W-1:0]  cur_end;

    typedef struct {
        logic        start;
        logic        rdy;
        logic        vld;
        logic [15:0] instr;
        logic [3:0]  pc;
        logic        busy;
        logic        done;
        logic [2:0]  qc;
    } vec_t;
    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic load(input logic [3:0] a, input logic [15:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        tick();
        prog_we = 1'b0;
        mdl_mem[a] = d;
    endtask

    task automatic build(input logic [3:0] f, input logic [3:0] t);
        logic [3:0] p;
        p = f;
        exp_q.push_back(p);
        while (p != t) begin
            p = p + 4'd1;
            exp_q.push_back(p);
        end
    endtask

    // One cycle-by-cycle pass of the basic 0..5 program with issue_ready held high.
    task automatic apply_table(input string tag);
        for (int i = 0; i < 11; i++) begin
            start = tbl[i].start; start_pc = 4'd0; end_pc = 4'd5; issue_ready = tbl[i].rdy;
            chk($sformatf("%s_c%0d_valid", tag, i), issue_valid, tbl[i].vld);
            if (tbl[i].vld) begin
                chk($sformatf("%s_c%0d_instr", tag, i), issue_instr, tbl[i].instr);
                chk($sformatf("%s_c%0d_pc", tag, i), issue_pc, tbl[i].pc);
            end
            chk($sformatf("%s_c%0d_busy", tag, i), busy, tbl[i].busy);
            chk($sformatf("%s_c%0d_done", tag, i), done, tbl[i].done);
            chk($sformatf("%s_c%0d_qcount", tag, i), q_count, tbl[i].qc);
            tick();
            start = 1'b0;
        end
        issue_ready = 1'b0;
    endtask

    // Drives one fetch run to completion, scoring every handshake against exp_q.
    task automatic run(input bit do_start, input logic [3:0] spc, input logic [3:0] epc,
                       input int rdy_pct, input int redir_at, input logic [3:0] rpc, input string tag);
        int cyc;
        if (do_start) begin
            exp_q.delete();
            build(spc, epc);
        end
        cur_end = epc;
        for (cyc = 0; cyc < 400; cyc++) begin
            if (done && cyc > 0) break;
            start       = do_start && (cyc == 0);
            start_pc    = spc;
            end_pc      = epc;
            issue_ready = ($urandom_range(99) < rdy_pct);
            redirect    = (cyc == redir_at) && (exp_q.size() != 0);
            redirect_pc = rpc;
            chk($sformatf("%s_valid_vs_count", tag), issue_valid, (q_count != 0));
            if (issue_valid && issue_ready) begin
                chk($sformatf("%s_issue_expected", tag), (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    chk($sformatf("%s_issue_pc", tag), issue_pc, exp_q[0]);
                    chk($sformatf("%s_issue_instr", tag), issue_instr, mdl_mem[exp_q[0]]);
                    void'(exp_q.pop_front());
                end
            end
            if (redirect) begin
                exp_q.delete();
                build(rpc, cur_end);
            end
            tick();
            start = 1'b0; redirect = 1'b0;
        end
        issue_ready = 1'b0;
        chk($sformatf("%s_done_reached", tag), done, 1);
        chk($sformatf("%s_all_issued", tag), exp_q.size(), 0);
        chk($sformatf("%s_busy_after", tag), busy, 0);
        chk($sformatf("%s_qcount_after", tag), q_count, 0);
    endtask

    initial begin
        logic [3:0] spc, epc, rpc;
        int rdy_pct, redir_at;

        rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0; start = 1'b0;
        start_pc = '0; end_pc = '0; redirect = 1'b0; redirect_pc = '0; issue_ready = 1'b0;
        tick(); tick();
        chk("rst_valid", issue_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_qcount", q_count, 0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            logic [15:0] d;
            case (i)
                0: d = 16'h2123;  1: d = 16'h0345;  2: d = 16'h0267;
                3: d = 16'h089A;  4: d = 16'h27AB;  5: d = 16'h1111;
                9: d = 16'hBEEF;
                default: d = 16'hA000 | 16'(i);
            endcase
            load(4'(i), d);
        end

        //          start rdy  vld  instr     pc    busy done qc
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0, 3'd0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 4'd0, 1'b1, 1'b0, 3'd0};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 16'h2123, 4'd0, 1'b1, 1'b0, 3'd1};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 16'h0345, 4'd1, 1'b1, 1'b0, 3'd1};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 16'h0267, 4'd2, 1'b1, 1'b0, 3'd1};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 16'h089A, 4'd3, 1'b1, 1'b0, 3'd1};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 16'h27AB, 4'd4, 1'b1, 1'b0, 3'd1};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 16'h1111, 4'd5, 1'b1, 1'b0, 3'd1};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 4'd0, 1'b1, 1'b0, 3'd0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b1, 3'd0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b1, 3'd0};
        apply_table("s1");

        // Backpressure: queue saturates and the head holds.
        exp_q.delete(); build(4'd0, 4'd5);
        start = 1'b1; start_pc = 4'd0; end_pc = 4'd5; issue_ready = 1'b0;
        tick(); start = 1'b0;
        repeat (9) tick();
        chk("s2_qcount_sat", q_count, QDEPTH);
        chk("s2_head_valid", issue_valid, 1);
        chk("s2_head_instr", issue_instr, 16'h2123);
        chk("s2_head_pc", issue_pc, 0);
        run(1'b0, 4'd0, 4'd5, 100, -1, 4'd0, "s2");

        // Redirect with three queued entries and a read in flight.
        start = 1'b1; start_pc = 4'd0; end_pc = 4'd10; issue_ready = 1'b0;
        tick(); start = 1'b0;
        repeat (3) tick();
        chk("s3_qcount_before", q_count, 3);
        redirect = 1'b1; redirect_pc = 4'd9;
        tick(); redirect = 1'b0;
        chk("s3_valid_after_redirect", issue_valid, 0);
        chk("s3_qcount_after_redirect", q_count, 0);
        exp_q.delete(); build(4'd9, 4'd10);
        run(1'b0, 4'd0, 4'd10, 100, -1, 4'd0, "s3");

        run(1'b1, 4'd14, 4'd1, 100, -1, 4'd0, "s4");

        // Reset mid-fetch, then the basic run must repeat exactly.
        start = 1'b1; start_pc = 4'd0; end_pc = 4'd5; issue_ready = 1'b0;
        tick(); start = 1'b0;
        repeat (2) tick();
        chk("s5_qcount_before", q_count, 2);
        rst = 1'b1;
        tick(); rst = 1'b0;
        chk("s5_valid", issue_valid, 0);
        chk("s5_qcount", q_count, 0);
        chk("s5_busy", busy, 0);
        chk("s5_done", done, 0);
        apply_table("s5");

        // Program write while busy must be dropped.
        exp_q.delete(); build(4'd0, 4'd5);
        start = 1'b1; start_pc = 4'd0; end_pc = 4'd5; issue_ready = 1'b0;
        tick(); start = 1'b0;
        prog_we = 1'b1; prog_addr = 4'd4; prog_data = 16'hDEAD;
        tick(); prog_we = 1'b0;
        run(1'b0, 4'd0, 4'd5, 100, -1, 4'd0, "s6a");

        // Redirect in the same cycle as a handshake: pc 1 still issues, then 3..5.
        run(1'b1, 4'd0, 4'd5, 100, 3, 4'd3, "s6b");

        for (int it = 0; it < 20; it++) begin
            for (int k = 0; k < 3; k++) load(4'($urandom), 16'($urandom));
            spc      = 4'($urandom);
            epc      = 4'($urandom);
            rpc      = 4'($urandom);
            rdy_pct  = 40 + int'($urandom_range(60));
            redir_at = ($urandom_range(1) == 1) ? int'($urandom_range(1, 12)) : -1;
            run(1'b1, spc, epc, rdy_pct, redir_at, rpc, $sformatf("rnd%0d", it));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
